// File: rtl/cache_pkg.sv
// Shared cache definitions: FSM state encoding and the address-split width helpers.
package cache_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        FILL
    } dcache_state_e;

    function automatic int offset_bits(input int line_size);
        return $clog2(line_size);
    endfunction

    function automatic int index_bits(input int cache_size, input int line_size);
        return $clog2(cache_size / line_size);
    endfunction

    function automatic int tag_bits(input int cache_size, input int line_size);
        return 32 - index_bits(cache_size, line_size) - offset_bits(line_size);
    endfunction

endpackage

// File: rtl/direct_map.sv
// Direct-mapped tag/valid/dirty/data array with a registered read port and one write port.
module direct_map
    import cache_pkg::*;
#(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write_valid,
    input  logic        write_access,
    input  logic [31:0] write_data,
    output logic        hit,
    output logic        dirty,
    output logic [31:0] data,
    output logic [31:0] invalidate_addr
);
    localparam int OFF_W = offset_bits(LINE_SIZE);
    localparam int IDX_W = index_bits(CACHE_SIZE, LINE_SIZE);
    localparam int TAG_W = tag_bits(CACHE_SIZE, LINE_SIZE);
    localparam int LINES = CACHE_SIZE / LINE_SIZE;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_q, dirty_q;

    logic [IDX_W-1:0] idx, rd_idx;
    logic [TAG_W-1:0] tag, rd_tag, lk_tag;
    logic             rd_valid, rd_dirty;
    logic [31:0]      rd_data;
    logic             unused_offset;

    assign idx           = addr[OFF_W +: IDX_W];
    assign tag           = addr[31 -: TAG_W];
    assign unused_offset = ^addr[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (write_valid) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (write_valid) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= write_access;
        end
    end

    // Read is sampled every edge; the owner only consumes it the cycle after presenting addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx   <= '0;
            rd_tag   <= '0;
            lk_tag   <= '0;
            rd_valid <= 1'b0;
            rd_dirty <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_idx   <= idx;
            rd_tag   <= tag_mem[idx];
            lk_tag   <= tag;
            rd_valid <= valid_q[idx];
            rd_dirty <= dirty_q[idx];
            rd_data  <= data_mem[idx];
        end
    end

    assign hit             = rd_valid && (rd_tag == lk_tag);
    assign dirty           = rd_valid && rd_dirty;
    assign data            = rd_data;
    assign invalidate_addr = {rd_tag, rd_idx, {OFF_W{1'b0}}};

endmodule

// File: rtl/dcache.sv
// Blocking write-back/write-allocate data cache around direct_map.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache
    import cache_pkg::*;
#(
    parameter int LINE_SIZE  = 4,
    parameter int CACHE_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    if (LINE_SIZE != WORD_BYTES) begin : g_bad_line_size
        $error("dcache: LINE_SIZE must be %0d", WORD_BYTES);
    end

    dcache_state_e state, state_nxt;
    logic [31:0] req_addr, req_wdata, victim_addr, victim_data, fill_data;
    logic        req_we;
    logic [31:0] arr_addr, arr_data, arr_victim, arr_wdata;
    logic        arr_hit, arr_dirty, arr_wr;

    assign arr_addr = (state == IDLE) ? cpu_addr : req_addr;

    direct_map #(
        .CACHE_SIZE (CACHE_SIZE),
        .LINE_SIZE  (LINE_SIZE)
    ) u_array (
        .clk             (clk),
        .rst             (rst),
        .addr            (arr_addr),
        .write_valid     (arr_wr),
        .write_access    (req_we),
        .write_data      (arr_wdata),
        .hit             (arr_hit),
        .dirty           (arr_dirty),
        .data            (arr_data),
        .invalidate_addr (arr_victim)
    );

    always_comb begin
        state_nxt  = state;
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        arr_wr     = 1'b0;
        arr_wdata  = req_wdata;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (arr_hit) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = arr_data;
                    arr_wr     = req_we;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = arr_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = victim_addr;
                mem_wdata = victim_data;
                if (mem_ack) state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_addr[31:2], 2'b00};
                if (mem_ack) state_nxt = FILL;
            end
            FILL: begin
                // A store miss overwrites the whole word, so the refill data is only returned on loads.
                arr_wr     = 1'b1;
                arr_wdata  = req_we ? req_wdata : fill_data;
                cpu_rvalid = 1'b1;
                cpu_rdata  = fill_data;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_addr    <= '0;
            req_we      <= 1'b0;
            req_wdata   <= '0;
            victim_addr <= '0;
            victim_data <= '0;
            fill_data   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_valid) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (state == LOOKUP && !arr_hit && arr_dirty) begin
                victim_addr <= arr_victim;
                victim_data <= arr_data;
            end
            if (state == REFILL && mem_ack) fill_data <= mem_rdata;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (arr_hit) hit_q  <= hit_q + 32'd1;
            else         miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random traffic against a behavioural cache model.
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    dcache #(.LINE_SIZE(4), .CACHE_SIZE(1024)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
    } mem_txn_t;

    mem_txn_t    mem_log[$];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ack_delay = 0;
    bit          rand_delay = 0;
    bit          spur_en = 0;
    int          unstable_cnt = 0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // Memory responder: acks each request after a chosen delay and logs completed transfers.
    bit       r_in_txn = 0;
    int       r_wait = 0;
    mem_txn_t r_cur;
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (rst) begin
                r_in_txn = 0;
            end else if (mem_req) begin
                if (!r_in_txn) begin
                    r_in_txn = 1;
                    r_cur.delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
                    r_wait = r_cur.delay;
                    r_cur.we = mem_we;
                    r_cur.addr = mem_addr;
                    r_cur.wdata = mem_wdata;
                end else if (mem_we !== r_cur.we || mem_addr !== r_cur.addr || mem_wdata !== r_cur.wdata) begin
                    unstable_cnt++;
                end
                if (r_wait == 0) begin
                    mem_ack = 1'b1;
                    r_in_txn = 0;
                    if (r_cur.we) bus_mem[r_cur.addr] = r_cur.wdata;
                    else mem_rdata = bus_rd(r_cur.addr);
                    mem_log.push_back(r_cur);
                end else begin
                    r_wait--;
                end
            end else begin
                r_in_txn = 0;
                if (spur_en) begin
                    mem_ack = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Behavioural model: 256 one-word lines, index = word address mod 256.
    bit          m_valid [256];
    bit          m_dirty [256];
    int unsigned m_tag   [256];
    logic [31:0] m_data  [256];
    int          m_hits, m_misses;

    bit          e_hit, e_wb;
    logic [31:0] e_wb_addr, e_wb_data, e_rdata;
    int          e_lat, e_nlog;
    int          o_wait, o_lat, o_seen, o_nlog;
    logic [31:0] o_rdata;
    mem_txn_t    o_t0, o_t1, o_rf;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic void model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned idx = (addr >> 2) % 256;
        int unsigned tag = addr >> 10;
        logic [31:0] wa = (addr >> 2) * 4;
        e_wb = 0;
        e_wb_addr = '0;
        e_wb_data = '0;
        e_hit = m_valid[idx] && m_tag[idx] == tag;
        if (e_hit) begin
            m_hits++;
            e_rdata = m_data[idx];
            if (we) begin
                m_data[idx] = wdata;
                m_dirty[idx] = 1;
            end
        end else begin
            m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                e_wb = 1;
                e_wb_addr = m_tag[idx] * 1024 + idx * 4;
                e_wb_data = m_data[idx];
                ref_mem[e_wb_addr] = m_data[idx];
            end
            e_rdata = ref_rd(wa);
            m_valid[idx] = 1;
            m_tag[idx] = tag;
            m_dirty[idx] = we;
            m_data[idx] = we ? wdata : e_rdata;
        end
        e_nlog = e_hit ? 0 : (e_wb ? 2 : 1);
    endfunction

    task automatic run_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int base = mem_log.size();
        model_access(we, addr, wdata);
        cpu_valid = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        o_wait = 0;
        while (!cpu_ready && o_wait < 50) begin
            @(posedge clk); #1;
            o_wait++;
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
        o_lat = 1;
        o_seen = 0;
        while (!cpu_rvalid && o_lat < 200) begin
            if (mem_req) o_seen++;
            @(posedge clk); #1;
            o_lat++;
        end
        o_rdata = cpu_rdata;
        o_nlog = mem_log.size() - base;
        o_t0 = '{we: 1'b0, addr: 32'hFFFF_FFFF, wdata: '0, delay: 0};
        o_t1 = o_t0;
        if (o_nlog > 0) o_t0 = mem_log[base];
        if (o_nlog > 1) o_t1 = mem_log[base + 1];
        o_rf = e_wb ? o_t1 : o_t0;
        e_lat = e_hit ? 1 : (e_wb ? 4 + o_t0.delay + o_t1.delay : 3 + o_t0.delay);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_valid = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cpu_ready, cpu_rvalid, mem_req, mem_we} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {cpu_ready, cpu_rvalid, mem_req, mem_we});
        end
        checks++;
        if ({cpu_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected zeros", cpu_rdata, mem_addr, mem_wdata);
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d expected 0 0", hit_cnt, miss_cnt);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_cold_load();
        bus_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        ack_delay = 0;
        run_req(1'b0, 32'h100, '0);
        checks++;
        if (o_nlog !== 1 || o_t0.we !== 1'b0 || o_t0.addr !== 32'h100) begin
            errors++;
            $display("FAIL cold_refill: got n=%0d we=%b addr=%h expected n=1 we=0 addr=00000100", o_nlog, o_t0.we, o_t0.addr);
        end
        checks++;
        if (o_rdata !== 32'hDEADBEEF || o_lat !== 3) begin
            errors++;
            $display("FAIL cold_data: got %h lat %0d expected deadbeef lat 3", o_rdata, o_lat);
        end
        run_req(1'b0, 32'h102, '0);
        checks++;
        if (o_lat !== 1 || o_seen !== 0 || o_nlog !== 0 || o_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cold_rehit: got lat %0d req %0d n %0d data %h expected 1 0 0 deadbeef", o_lat, o_seen, o_nlog, o_rdata);
        end
    endtask

    task automatic test_evict();
        run_req(1'b1, 32'h100, 32'h12345678);
        checks++;
        if (o_lat !== 1 || o_nlog !== 0) begin
            errors++;
            $display("FAIL evict_store_hit: got lat %0d n %0d expected 1 0", o_lat, o_nlog);
        end
        run_req(1'b0, 32'h500, '0);
        checks++;
        if (o_nlog !== 2 || o_t0.we !== 1'b1 || o_t0.addr !== 32'h100 || o_t0.wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL evict_wb: got n=%0d we=%b addr=%h data=%h expected 2 1 00000100 12345678", o_nlog, o_t0.we, o_t0.addr, o_t0.wdata);
        end
        checks++;
        if (o_t1.we !== 1'b0 || o_t1.addr !== 32'h500 || o_rdata !== e_rdata || o_lat !== 4) begin
            errors++;
            $display("FAIL evict_refill: got we=%b addr=%h data=%h lat %0d expected 0 00000500 %h 4", o_t1.we, o_t1.addr, o_rdata, o_lat, e_rdata);
        end
    endtask

    task automatic test_store_miss();
        run_req(1'b1, 32'h204, 32'hCAFE0204);
        checks++;
        if (o_nlog !== 1 || o_t0.we !== 1'b0 || o_t0.addr !== 32'h204 || o_lat !== 3) begin
            errors++;
            $display("FAIL smiss_refill: got n=%0d we=%b addr=%h lat %0d expected 1 0 00000204 3", o_nlog, o_t0.we, o_t0.addr, o_lat);
        end
        run_req(1'b0, 32'h204, '0);
        checks++;
        if (o_rdata !== 32'hCAFE0204 || o_seen !== 0 || o_lat !== 1 || o_wait !== 1) begin
            errors++;
            $display("FAIL smiss_reload: got %h req %0d lat %0d wait %0d expected cafe0204 0 1 1", o_rdata, o_seen, o_lat, o_wait);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        run_req(1'b0, 32'h40, '0);
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            run_req(1'b1, 32'h40, v);
            run_req(1'b0, 32'h40, '0);
            checks++;
            if (o_wait !== 1 || o_lat !== 1 || o_rdata !== v) begin
                errors++;
                $display("FAIL b2b_hit: got wait %0d lat %0d data %h expected 1 1 %h", o_wait, o_lat, o_rdata, v);
            end
        end
    endtask

    task automatic test_ack_delay();
        int d;
        logic [31:0] a;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 0 : (k == 1) ? 1 : 7;
            ack_delay = d;
            a = 32'h800 + k * 4;
            unstable_cnt = 0;
            run_req(1'b1, a, 32'hA0A0_0000 + k);
            checks++;
            if (o_lat !== 3 + d) begin
                errors++;
                $display("FAIL ack_clean_lat d=%0d: got %0d expected %0d", d, o_lat, 3 + d);
            end
            run_req(1'b0, a + 32'h400, '0);
            checks++;
            if (o_lat !== 4 + 2 * d || o_nlog !== 2 || o_t0.wdata !== 32'hA0A0_0000 + k) begin
                errors++;
                $display("FAIL ack_dirty d=%0d: got lat %0d n %0d wb %h expected %0d 2 %h", d, o_lat, o_nlog, o_t0.wdata, 4 + 2 * d, 32'hA0A0_0000 + k);
            end
            checks++;
            if (unstable_cnt !== 0) begin
                errors++;
                $display("FAIL ack_stable d=%0d: got %0d changes expected 0", d, unstable_cnt);
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ack_delay = 20;
        cpu_valid = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h300;
        while (!cpu_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        n = 0;
        while (!(mem_req && !mem_we) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(mem_req && !mem_we && mem_addr == 32'h300)) begin
            errors++;
            $display("FAIL rstmid_refill: got req %b we %b addr %h expected 1 0 00000300", mem_req, mem_we, mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cpu_ready, cpu_rvalid, mem_req, mem_we} !== 4'b1000 || {cpu_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL rstmid_async: got ctl %b addr %h expected 1000 00000000", {cpu_ready, cpu_rvalid, mem_req, mem_we}, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        ack_delay = 0;
        @(posedge clk); #1;
        run_req(1'b0, 32'h300, '0);
        checks++;
        if (o_nlog !== 1 || o_lat !== 3 || o_rdata !== e_rdata) begin
            errors++;
            $display("FAIL rstmid_remiss: got n %0d lat %0d data %h expected 1 3 %h", o_nlog, o_lat, o_rdata, e_rdata);
        end
    endtask

    task automatic test_perf_cnt();
        int exp_h, exp_m;
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        run_req(1'b0, 32'h140, '0);
        run_req(1'b0, 32'h140, '0);
        run_req(1'b1, 32'h140, 32'h0BADF00D);
        run_req(1'b0, 32'h180, '0);
        run_req(1'b0, 32'h180, '0);
        @(posedge clk); #1;
`ifdef DCACHE_PERF_CNT_EN
        exp_h = m_hits;
        exp_m = m_misses;
`else
        exp_h = 0;
        exp_m = 0;
`endif
        checks++;
        if (hit_cnt !== exp_h || miss_cnt !== exp_m) begin
            errors++;
            $display("FAIL perf_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_h, exp_m);
        end
    endtask

    task automatic test_random();
        bit we;
        logic [31:0] a, w;
        int exp_h, exp_m;
        rand_delay = 1;
        spur_en = 1;
        unstable_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            w = $urandom;
            run_req(we, a, w);
            checks++;
            if (o_lat !== e_lat || o_nlog !== e_nlog) begin
                errors++;
                $display("FAIL rand_timing #%0d addr %h: got lat %0d n %0d expected %0d %0d", i, a, o_lat, o_nlog, e_lat, e_nlog);
            end
            if (e_wb) begin
                checks++;
                if (o_t0.we !== 1'b1 || o_t0.addr !== e_wb_addr || o_t0.wdata !== e_wb_data) begin
                    errors++;
                    $display("FAIL rand_wb #%0d: got %b %h %h expected 1 %h %h", i, o_t0.we, o_t0.addr, o_t0.wdata, e_wb_addr, e_wb_data);
                end
            end
            if (!e_hit) begin
                checks++;
                if (o_rf.we !== 1'b0 || o_rf.addr !== {a[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rand_refill #%0d: got %b %h expected 0 %h", i, o_rf.we, o_rf.addr, {a[31:2], 2'b00});
                end
            end
            if (!we) begin
                checks++;
                if (o_rdata !== e_rdata) begin
                    errors++;
                    $display("FAIL rand_rdata #%0d addr %h: got %h expected %h", i, a, o_rdata, e_rdata);
                end
            end
        end
        spur_en = 0;
        rand_delay = 0;
        @(posedge clk); #1;
        checks++;
        if (unstable_cnt !== 0) begin
            errors++;
            $display("FAIL rand_stable: got %0d changes expected 0", unstable_cnt);
        end
`ifdef DCACHE_PERF_CNT_EN
        exp_h = m_hits;
        exp_m = m_misses;
`else
        exp_h = 0;
        exp_m = 0;
`endif
        checks++;
        if (hit_cnt !== exp_h || miss_cnt !== exp_m) begin
            errors++;
            $display("FAIL rand_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_h, exp_m);
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_evict();
        test_store_miss();
        test_back_to_back();
        test_ack_delay();
        test_reset_mid();
        test_perf_cnt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache.md
# dcache

Single-port, blocking, write-back/write-allocate data cache that wraps the `direct_map` tag/data array and drives it from both ends. It accepts load/store requests from the LSU on a valid/ready interface and runs lookup, dirty-line write-back and refill against the memory bus through a req/ack handshake. It sits between the core's memory stage and the system memory arbiter.

## Interface
Parameters:
- `LINE_SIZE`, 4: bytes per line. Fixed at 4, so a line is one 32-bit word; any other value is a compile-time error.
- `CACHE_SIZE`, 1024: capacity in bytes; passed through to the array.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_valid` in 1: request valid.
- `cpu_ready` out 1: request accepted when `cpu_valid && cpu_ready`.
- `cpu_addr` in 32: byte address; bits [1:0] are ignored.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_wdata` in 32: store data (full word).
- `cpu_rvalid` out 1: one-cycle completion pulse for loads and stores.
- `cpu_rdata` out 32: load data, valid only while `cpu_rvalid` is high and the request is a load.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write-back, 0 = refill read.
- `mem_addr` out 32: word-aligned address, with [1:0] = 0.
- `mem_wdata` out 32: write-back data.
- `mem_ack` in 1: one-cycle completion pulse; only meaningful while `mem_req` is high.
- `mem_rdata` in 32: refill data, valid with `mem_ack`.
- `hit_cnt` out 32: hit counter (see Configuration).
- `miss_cnt` out 32: miss counter (see Configuration).

## Operation
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, FILL.
- IDLE
  - `cpu_ready`=1.
  - The array address is driven combinationally from `cpu_addr`.
  - On accept: latch addr, `we` and `wdata` into request registers, then go to LOOKUP.
- LOOKUP
  - The array address comes from the latched address; the array's `hit`/`dirty`/`data` outputs are valid in this state.
  - Read hit: `cpu_rvalid`=1, `cpu_rdata`=array data, go to IDLE.
  - Write hit: assert array `write_valid` with `write_access`=1 and `write_data`=latched wdata; pulse `cpu_rvalid`; go to IDLE. The line becomes dirty.
  - Miss with dirty victim: latch `invalidate_addr` and the victim data, then go to WRITEBACK.
  - Miss with clean or invalid line: go to REFILL.
- WRITEBACK
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`=latched victim address, `mem_wdata`=latched victim data.
  - Hold all four stable until `mem_ack`, then go to REFILL.
- REFILL
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`={addr[31:2], 2'b00}.
  - On `mem_ack`: latch `mem_rdata`, go to FILL.
- FILL
  - Load miss: write the array with the refill data and `write_access`=0 (line clean). `cpu_rvalid`=1, `cpu_rdata`=refill data.
  - Store miss: write the array with the latched wdata and `write_access`=1 (line dirty). Pulse `cpu_rvalid`; the refill data is discarded.
  - Go to IDLE.
- `mem_ack` is ignored whenever `mem_req` is low.
- At most one request is outstanding; `cpu_ready`=0 in every state except IDLE.

## Timing
- Reset values: state=IDLE, `cpu_ready`=1, `cpu_rvalid`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, counters=0.
- Assertion of `rst` mid-transaction immediately drops `mem_req` and abandons the transaction. The memory side must tolerate this.
- All outputs are registered or decoded from state plus latched registers. No path runs from `cpu_*` inputs to `mem_*` outputs.
- Hit, accepted in cycle t: `cpu_rvalid` in t+1; the next accept is possible in t+2.
- Clean miss, accepted in t: `mem_req` rises in t+2. If `mem_ack` arrives in cycle k, `cpu_rvalid` is in k+1.
- Dirty miss: write-back `mem_req` rises in t+2. When it is acked in k1, the refill `mem_req` starts in k1+1; its ack in k2 gives `cpu_rvalid` in k2+1.
- `mem_ack` may arrive in the first cycle of `mem_req`.
- The array write in FILL commits on the edge leaving FILL, so a lookup of the same address accepted in the following IDLE cycle hits.

## Configuration
- `DCACHE_PERF_CNT_EN` defined:
  - `hit_cnt` increments in LOOKUP on a hit.
  - `miss_cnt` increments in LOOKUP on a miss.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package `cache_pkg` holds:
  - the state enum `dcache_state_e`;
  - `WORD_BYTES`=4;
  - the index/offset/tag width functions derived from `CACHE_SIZE` and `LINE_SIZE`.
- One sub-module: `direct_map` holds the tag/valid/dirty and data arrays. It is instantiated once, and its `addr` is muxed between `cpu_addr` (IDLE) and the latched address (all other states).

## Test plan
- Cold load from 0x100 with memory returning 0xDEADBEEF:
  - refill read at 0x100, with no write-back;
  - `cpu_rdata`=0xDEADBEEF;
  - a second load from 0x100 hits with `cpu_rvalid` one cycle after accept and no `mem_req`.
- Store 0x12345678 to 0x100 (hit), then load from 0x500, which maps to the same index (CACHE_SIZE=1024):
  - write-back of 0x12345678 to 0x100 comes first;
  - then a refill read from 0x500.
- Store miss to 0x204:
  - refill issued;
  - a following load of 0x204 returns the stored data without `mem_req`.
- `mem_ack` delayed by 0, 1 and 7 cycles: `mem_addr`/`mem_we`/`mem_wdata` stay stable throughout, and `cpu_rvalid` comes exactly one cycle after the ack.
- `rst` pulsed during REFILL:
  - `mem_req` drops asynchronously and all outputs return to their reset values;
  - after release, a load from the same address misses again.
- With `DCACHE_PERF_CNT_EN` defined: 3 hits and 2 misses give `hit_cnt`=3 and `miss_cnt`=2. Without the macro, both stay 0.
